// File: rtl/shifter_pipe_if.sv
// Operation bus of the pipelined shifter: an input side carrying each operation
// and an output side returning results, both with valid/ready flow control.
interface shifter_pipe_if #(
  parameter int DATA_WDTH = 32,
  parameter int TAG_WDTH  = 4
);
  localparam int SV_WDTH = $clog2(DATA_WDTH);

  logic                 in_valid;
  logic                 in_ready;
  logic [SV_WDTH-1:0]   in_sv;
  logic [DATA_WDTH-1:0] in_data;
  logic [2:0]           in_op;
  logic [TAG_WDTH-1:0]  in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_WDTH-1:0] out_data;
  logic [TAG_WDTH-1:0]  out_tag;
  logic                 out_zero;
  logic                 out_err;

  // Producer of operations and consumer of results.
  modport master (
    output in_valid, in_sv, in_data, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero, out_err
  );

  // The shifter unit itself.
  modport slave (
    input  in_valid, in_sv, in_data, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero, out_err
  );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator: log2(DATA_WDTH) shift levels, a register
// after every REG_EVERY levels, tag/error sideband and a global-stall handshake.
module shifter_pipe #(
  parameter int DATA_WDTH = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_WDTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  shifter_pipe_if.slave  bus
);
  localparam int SV_WDTH = $clog2(DATA_WDTH);
  localparam int STAGES  = (SV_WDTH + REG_EVERY - 1) / REG_EVERY;
  localparam int CTRL_N  = (STAGES > 1) ? STAGES - 1 : 1;

  if (DATA_WDTH < 8 || (DATA_WDTH & (DATA_WDTH - 1)) != 0) begin : g_bad_width
    $error("shifter_pipe: DATA_WDTH must be a power of two and at least 8");
  end
  if (REG_EVERY < 1 || REG_EVERY > SV_WDTH) begin : g_bad_reg_every
    $error("shifter_pipe: REG_EVERY must lie in 1..SV_WDTH");
  end

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  typedef struct packed {
    logic                 valid;
    logic [DATA_WDTH-1:0] data;
    logic [TAG_WDTH-1:0]  tag;
    logic                 err;
  } stage_t;

  // Shift amount and opcode only travel to stages that still have levels to apply.
  typedef struct packed {
    logic [SV_WDTH-1:0] sv;
    logic [2:0]         op;
  } ctrl_t;

  // One level shifts or rotates by exactly 2^lvl; illegal opcodes pass data through.
  function automatic logic [DATA_WDTH-1:0] shift_level(
    input logic [DATA_WDTH-1:0] d,
    input logic [2:0]           op,
    input int                   lvl
  );
    int k;
    k = 1 << lvl;
    case (op)
      OP_SLL:  shift_level = d << k;
      OP_SRL:  shift_level = d >> k;
      OP_SRA:  shift_level = $signed(d) >>> k;
      OP_ROL:  shift_level = (d << k) | (d >> (DATA_WDTH - k));
      OP_ROR:  shift_level = (d >> k) | (d << (DATA_WDTH - k));
      default: shift_level = d;
    endcase
  endfunction

  stage_t stg_q [STAGES];
  stage_t stg_d [STAGES];
  ctrl_t  ctl_q [CTRL_N];
  ctrl_t  ctl_d [CTRL_N];
  logic   zero_q;
  logic   stall;
  stage_t bus_stage;
  ctrl_t  bus_ctrl;

  assign stall        = stg_q[STAGES-1].valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  assign bus_stage.valid = bus.in_valid && bus.in_ready;
  assign bus_stage.data  = bus.in_data;
  assign bus_stage.tag   = bus.in_tag;
  assign bus_stage.err   = bus.in_op > OP_ROR;
  assign bus_ctrl.sv     = bus.in_sv;
  assign bus_ctrl.op     = bus.in_op;

  always_comb begin
    stage_t src;
    ctrl_t  c;
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path can leave it holding a value (no latch).
    src   = bus_stage;
    c     = bus_ctrl;
    stg_d = '{default: '0};
    ctl_d = '{default: '0};
    for (int s = 0; s < STAGES; s++) begin
      if (s > 0) begin
        src = stg_q[s-1];
        c   = ctl_q[s-1];
      end
      stg_d[s] = src;
      if (s < STAGES - 1) ctl_d[s] = c;
      for (int l = 0; l < SV_WDTH; l++) begin
        if ((l / REG_EVERY) == s && c.sv[l]) begin
          stg_d[s].data = shift_level(stg_d[s].data, c.op, l);
        end
      end
    end
  end

  // NOTE: the datapath registers are reset too, because the result bus must
  // read all-zero straight out of reset, not just show out_valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) stg_q[s] <= '0;
      for (int s = 0; s < CTRL_N; s++) ctl_q[s] <= '0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's pre-edge value, independent of statement order.
      for (int s = 0; s < STAGES; s++) stg_q[s] <= stg_d[s];
      for (int s = 0; s < CTRL_N; s++) ctl_q[s] <= ctl_d[s];
      zero_q <= (stg_d[STAGES-1].data == '0);
    end
  end

  assign bus.out_valid = stg_q[STAGES-1].valid;
  assign bus.out_data  = stg_q[STAGES-1].data;
  assign bus.out_tag   = stg_q[STAGES-1].tag;
  assign bus.out_err   = stg_q[STAGES-1].err;
  assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe: directed cases, FIFO/back-pressure,
// randomized traffic against a one-shot reference model, mid-flight reset.
module tb_shifter_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  shifter_pipe_if #(.DATA_WDTH(32), .TAG_WDTH(4)) bus   ();
  shifter_pipe_if #(.DATA_WDTH(64), .TAG_WDTH(4)) bus64 ();
  shifter_pipe_if #(.DATA_WDTH(32), .TAG_WDTH(4)) bus1  ();

  shifter_pipe #(.DATA_WDTH(32), .REG_EVERY(2), .TAG_WDTH(4)) dut   (.clk(clk), .rst(rst), .bus(bus));
  shifter_pipe #(.DATA_WDTH(64), .REG_EVERY(1), .TAG_WDTH(4)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
  shifter_pipe #(.DATA_WDTH(32), .REG_EVERY(5), .TAG_WDTH(4)) dut1  (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic        was_stalled = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_tag;
  int          xfers, xfer_first, xfer_last, cyc, stall_cycles;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One-shot definitions of each operation, straight from the operation table.
  function automatic logic [31:0] ref32(input logic [31:0] d, input logic [4:0] sv, input logic [2:0] op);
    case (op)
      3'd0:    return d << sv;
      3'd1:    return d >> sv;
      3'd2:    return $signed(d) >>> sv;
      3'd3:    return (sv == 0) ? d : ((d << sv) | (d >> (32 - sv)));
      3'd4:    return (sv == 0) ? d : ((d >> sv) | (d << (32 - sv)));
      default: return d;
    endcase
  endfunction

  // One clock of the main DUT: entered and left at posedge+1.
  task automatic tick(input logic v, input logic [2:0] op, input logic [31:0] d,
                      input logic [4:0] sv, input logic [3:0] tag, input logic ordy,
                      output logic accepted);
    exp_t e;
    if (was_stalled) begin
      check("held valid", bus.out_valid, 1'b1);
      check("held data", bus.out_data, held_data);
      check("held tag", bus.out_tag, held_tag);
    end
    bus.in_valid = v; bus.in_op = op; bus.in_data = d; bus.in_sv = sv; bus.in_tag = tag;
    bus.out_ready = ordy;
    #1;
    check("in_ready", bus.in_ready, !(bus.out_valid && !ordy));
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) begin
        check("unexpected result", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_tag", bus.out_tag, e.tag);
        check("out_err", bus.out_err, e.err);
        check("out_zero", bus.out_zero, e.data == 32'd0);
      end
      if (xfers == 0) xfer_first = cyc;
      xfer_last = cyc;
      xfers++;
    end
    accepted = v && bus.in_ready;
    if (accepted) q.push_back('{ref32(d, sv, op), tag, op > 3'd4});
    was_stalled = bus.out_valid && !ordy;
    held_data = bus.out_data;
    held_tag  = bus.out_tag;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    logic acc;
    int guard = 0;
    while (q.size() > 0 && guard < 50) begin
      tick(1'b0, 3'd0, 32'd0, 5'd0, 4'd0, 1'b1, acc);
      guard++;
    end
    check("drain empty", q.size(), 0);
  endtask

  // Single isolated op on the main DUT with exact latency check (L=3).
  task automatic run_one(input string name, input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] sv, input logic [3:0] tag,
                         input logic [31:0] exp_data, input logic exp_err);
    int n;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_data = d; bus.in_sv = sv; bus.in_tag = tag;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({name, " latency"}, n, 3);
    check({name, " data"}, bus.out_data, exp_data);
    check({name, " tag"}, bus.out_tag, tag);
    check({name, " zero"}, bus.out_zero, exp_data == 32'd0);
    check({name, " err"}, bus.out_err, exp_err);
    @(posedge clk); #1;
    check({name, " single pulse"}, bus.out_valid, 1'b0);
    was_stalled = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   n, idx, pulses;
    logic [3:0] tagc;

    bus.in_valid = 0;   bus.in_op = 0;   bus.in_data = 0;   bus.in_sv = 0;   bus.in_tag = 0;   bus.out_ready = 1;
    bus64.in_valid = 0; bus64.in_op = 0; bus64.in_data = 0; bus64.in_sv = 0; bus64.in_tag = 0; bus64.out_ready = 1;
    bus1.in_valid = 0;  bus1.in_op = 0;  bus1.in_data = 0;  bus1.in_sv = 0;  bus1.in_tag = 0;  bus1.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst out_data", bus.out_data, 32'd0);
    check("rst out_tag", bus.out_tag, 4'd0);
    check("rst out_zero", bus.out_zero, 1'b0);
    check("rst out_err", bus.out_err, 1'b0);
    check("rst in_ready", bus.in_ready, 1'b1);
    check("rst64 out_valid", bus64.out_valid, 1'b0);
    check("rst1 out_valid", bus1.out_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_one("sll f1", 3'b000, 32'h0000_00F1, 5'd4, 4'd3, 32'h0000_0F10, 1'b0);
    run_one("sra", 3'b010, 32'h8000_0000, 5'd31, 4'd1, 32'hFFFF_FFFF, 1'b0);
    run_one("srl", 3'b001, 32'h8000_0000, 5'd31, 4'd2, 32'h0000_0001, 1'b0);
    run_one("ror", 3'b100, 32'h0000_0001, 5'd1, 4'd4, 32'h8000_0000, 1'b0);
    run_one("rol", 3'b011, 32'h8000_0001, 5'd4, 4'd5, 32'h0000_0018, 1'b0);
    run_one("sll sv0", 3'b000, 32'h0000_0001, 5'd0, 4'd6, 32'h0000_0001, 1'b0);
    run_one("illegal", 3'b110, 32'hDEAD_BEEF, 5'd7, 4'd7, 32'hDEAD_BEEF, 1'b1);
    run_one("srl zero", 3'b001, 32'h0000_00FF, 5'd8, 4'd8, 32'h0000_0000, 1'b0);

    // Back-to-back stream, tags 0..7, no back-pressure.
    xfers = 0; cyc = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 3'(i % 5), $urandom, 5'($urandom), 4'(i), 1'b1, acc);
      check("stream accept", acc, 1'b1);
    end
    drain();
    check("stream count", xfers, 8);
    check("stream back-to-back", xfer_last - xfer_first, 7);

    // Same stream with out_ready dropped for 5 cycles while tag 2 is presented.
    xfers = 0; idx = 0; stall_cycles = 0; n = 0;
    while (idx < 8 && n < 60) begin
      if (bus.out_valid && bus.out_tag == 4'd2 && stall_cycles < 5) begin
        stall_cycles++;
        tick(1'b1, 3'(idx % 5), 32'h1234_5678 + idx, 5'(idx * 3), 4'(idx), 1'b0, acc);
      end else begin
        tick(1'b1, 3'(idx % 5), 32'h1234_5678 + idx, 5'(idx * 3), 4'(idx), 1'b1, acc);
      end
      if (acc) idx++;
      n++;
    end
    drain();
    check("bp stall cycles", stall_cycles, 5);
    check("bp count", xfers, 8);

    // Randomized traffic with random back-pressure.
    xfers = 0; tagc = 4'd0;
    for (int i = 0; i < 300; i++) begin
      tick($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, 5'($urandom),
           tagc, $urandom_range(0, 3) != 0, acc);
      if (acc) tagc++;
    end
    drain();

    // Reset with operations in flight: one at the output, two behind it.
    for (int i = 0; i < 3; i++) tick(1'b1, 3'd0, 32'hFFFF_0000 | i, 5'd1, 4'(9 + i), 1'b1, acc);
    tick(1'b0, 3'd0, 32'd0, 5'd0, 4'd0, 1'b0, acc);
    check("pre-rst out_valid", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", bus.out_valid, 1'b0);
    check("async rst out_data", bus.out_data, 32'd0);
    check("async rst out_tag", bus.out_tag, 4'd0);
    check("async rst out_zero", bus.out_zero, 1'b0);
    check("async rst out_err", bus.out_err, 1'b0);
    check("async rst in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    was_stalled = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) pulses++;
      tick(1'b0, 3'd0, 32'd0, 5'd0, 4'd0, 1'b1, acc);
    end
    check("post-rst pulses", pulses, 0);
    run_one("post-rst sll", 3'b000, 32'h0000_00F1, 5'd4, 4'd3, 32'h0000_0F10, 1'b0);

    // 64-bit, one level per stage: latency 6.
    bus64.in_valid = 1'b1; bus64.in_op = 3'b000; bus64.in_data = 64'hF1; bus64.in_sv = 6'd4; bus64.in_tag = 4'd3;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    n = 1;
    while (!bus64.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("w64 latency", n, 6);
    check("w64 data", bus64.out_data, 64'hF10);
    check("w64 tag", bus64.out_tag, 4'd3);
    check("w64 zero", bus64.out_zero, 1'b0);
    check("w64 err", bus64.out_err, 1'b0);

    // All levels in one stage: latency 1.
    bus1.in_valid = 1'b1; bus1.in_op = 3'b000; bus1.in_data = 32'hF1; bus1.in_sv = 5'd4; bus1.in_tag = 4'd3;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    n = 1;
    while (!bus1.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("l1 latency", n, 1);
    check("l1 data", bus1.out_data, 32'hF10);
    check("l1 tag", bus1.out_tag, 4'd3);
    check("l1 err", bus1.out_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
Pipelined, parametrised successor to the ALU combinational shifter. It adds data width generalisation, rotate modes, a configurable pipeline depth, a sideband tag and valid/ready flow control. It sits between the ALU operand stage and writeback as a multi-cycle functional unit. Back-pressure from writeback stalls the whole pipe without losing data.

Parameters:
DATA_WDTH, 32, data width; must be a power of two and at least 8 (elaboration error otherwise).
SV_WDTH, $clog2(DATA_WDTH), shift-amount width; derived, not overridable.
REG_EVERY, 2, number of shift levels per pipeline stage; range 1..SV_WDTH.
TAG_WDTH, 4, width of the opaque sideband tag carried alongside each operation.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation present on the input bus
in_ready  output  1  unit accepts the operation this cycle
in_sv  input  SV_WDTH  shift amount
in_data  input  DATA_WDTH  operand
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101..111 illegal
in_tag  input  TAG_WDTH  sideband tag, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_data  output  DATA_WDTH  result
out_tag  output  TAG_WDTH  tag of the result
out_zero  output  1  out_data == 0
out_err  output  1  operation used an illegal opcode

Behaviour:
- Reset (async assert, sync release): all stage valid bits cleared. out_valid=0, out_data=0, out_tag=0, out_zero=0, out_err=0, in_ready=1.
- Structure: SV_WDTH shift levels; level i shifts or rotates by 2^i when sv[i]=1. A pipeline register follows every REG_EVERY levels, and the last level is always registered.
- Latency L = ceil(SV_WDTH/REG_EVERY) cycles from accept to out_valid when there is no stall. Defaults give L=3. Each stage register holds valid, partial data, remaining sv bits, op, tag and err.
- Functions, with results identical to the one-shot definitions:
  - SLL: data << sv, zero fill.
  - SRL: data >> sv, zero fill.
  - SRA: fill with data[DATA_WDTH-1].
  - ROL: (data << sv) | (data >> (DATA_WDTH-sv)); sv=0 returns data.
  - ROR: mirror of ROL.
- Illegal op: data passes through unshifted; out_err=1 together with that result; no other effect.
- out_zero is computed from the final-stage data, registered with it.
- Handshake:
  - Accept when in_valid && in_ready.
  - Transfer when out_valid && out_ready.
  - Global stall: stall = out_valid && !out_ready. While stalled, every stage register holds and in_ready=0 (combinational from out_valid, out_ready).
  - When not stalled, all stages advance every cycle. Bubbles propagate; they are not compressed.
- out_* are stable while out_valid && !out_ready.
- With out_ready held high, throughput is 1 operation per cycle.
- Inputs are ignored when in_valid=0 or in_ready=0. The input stage captures valid=0 when not accepting and not stalled.
- Ordering is strictly FIFO; tags are never reordered.
- Reset mid-operation: in-flight operations are discarded with no output pulse. The first accept after release appears L cycles later.

Test Plan:
- DATA_WDTH=32, REG_EVERY=2, out_ready=1: SLL in_data=0x0000_00F1, sv=4, tag=3. Response: 3 cycles later out_valid=1, out_data=0x0000_0F10, out_tag=3, out_zero=0, out_err=0.
- SRA 0x8000_0000 sv=31 gives 0xFFFF_FFFF. SRL on the same operands gives 0x0000_0001. ROR 0x0000_0001 sv=1 gives 0x8000_0000. ROL 0x8000_0001 sv=4 gives 0x0000_0018. SLL 0x1 sv=0 gives 0x1.
- Back-to-back stream of 8 ops, tags 0..7, with out_ready=1. Expect 8 consecutive out_valid cycles, tags in order 0..7, in_ready constantly 1.
- Back-pressure: same stream, but drop out_ready for 5 cycles while the result for tag 2 is presented. Expect in_ready=0 and out_data/out_tag held at tag 2 for all 5 cycles, then tags 3..7 in order with no loss or duplication.
- in_op=110, in_data=0xDEAD_BEEF, sv=7. Expect out_data=0xDEAD_BEEF, out_err=1. Next op SRL 0x0000_00FF sv=8 gives 0, out_zero=1, out_err=0.
- Assert rst with 2 ops in flight. Expect all outputs 0 immediately (asynchronously) and no output from those ops after release. Also re-run the first scenario at DATA_WDTH=64, REG_EVERY=1 (L=6) and at REG_EVERY=SV_WDTH (L=1).
